// File: rtl/pcpi_pkg.sv
// ---------------------------------------------------------------------------
// pcpi_pkg: shared decode constants and enums for the PCPI multiplier shim.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pcpi_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_RESP  = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;
  localparam logic [2:0] ST_DRAIN = 3'd5;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_t;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    WAIT  = ST_WAIT,
    RESP  = ST_RESP,
    HOLD  = ST_HOLD,
    DRAIN = ST_DRAIN
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pcpi_mul_decode.sv
// ---------------------------------------------------------------------------
// pcpi_mul_decode: RV32M multiply decode and 33-bit operand extension.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pcpi_mul_decode
  import pcpi_pkg::*;
(
  input  logic [31:0] insn_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  output logic        hit_o,
  output mul_op_t     op_o,
  output logic [32:0] mul_a_o,
  output logic [32:0] mul_b_o
);

  logic a_signed;
  logic b_signed;
  logic unused_insn;

  assign unused_insn = ^{insn_i[24:15], insn_i[11:7]};

  always_comb begin
    hit_o    = (insn_i[6:0] == OPC_OP) && (insn_i[31:25] == F7_MULDIV) && !insn_i[14];
    op_o     = mul_op_t'(insn_i[13:12]);
    a_signed = (op_o != MULHU);
    b_signed = (op_o == MUL) || (op_o == MULH);
    mul_a_o  = {a_signed & rs1_i[31], rs1_i};
    mul_b_o  = {b_signed & rs2_i[31], rs2_i};
  end

endmodule

`default_nettype wire

// File: rtl/pcpi_mul_shim.sv
// ---------------------------------------------------------------------------
// pcpi_mul_shim: PCPI front end issuing RV32M multiplies to a 33x33 core.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pcpi_mul_shim
  import pcpi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic        mul_req_valid,
  input  logic        mul_req_ready,
  output logic [32:0] mul_a,
  output logic [32:0] mul_b,
  input  logic        mul_rsp_valid,
  input  logic [63:0] mul_rsp_data,
  output logic        err_timeout
);

  logic        dec_hit;
  mul_op_t     dec_op;
  logic [32:0] dec_a;
  logic [32:0] dec_b;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_tick;
  logic [32:0]      a_q, a_d, b_q, b_d;
  mul_op_t          op_q, op_d;
  logic [31:0]      res_q, res_d;
  logic             wr_q, wr_d;
  logic             abort_q, abort_d;
  logic             err_q, err_d;
  logic             tmo;
  logic [31:0]      rsp_sel;

  pcpi_mul_decode u_decode (
    .insn_i  (pcpi_insn),
    .rs1_i   (pcpi_rs1),
    .rs2_i   (pcpi_rs2),
    .hit_o   (dec_hit),
    .op_o    (dec_op),
    .mul_a_o (dec_a),
    .mul_b_o (dec_b)
  );

  // Watchdog: a request may be outstanding for TIMEOUT_CYCLES cycles in ISSUE/WAIT.
  assign cnt_tick = cnt_q + 1'b1;
  assign tmo      = (TIMEOUT_CYCLES != 0) && (cnt_tick >= CNT_W'(TIMEOUT_CYCLES));
  assign rsp_sel  = (op_q == MUL) ? mul_rsp_data[31:0] : mul_rsp_data[63:32];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    wr_d    = wr_q;
    abort_d = abort_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (pcpi_valid && dec_hit) begin
          a_d     = dec_a;
          b_d     = dec_b;
          op_d    = dec_op;
          cnt_d   = '0;
          abort_d = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = cnt_tick;
        // The request cannot be retracted, so a dropped valid is remembered here.
        abort_d = abort_q | ~pcpi_valid;
        if (mul_req_ready && mul_rsp_valid) begin
          if (abort_d) begin
            state_d = HOLD;
          end else begin
            res_d   = rsp_sel;
            wr_d    = 1'b1;
            state_d = RESP;
          end
        end else if (mul_req_ready && abort_d) begin
          state_d = DRAIN;
        end else if (tmo) begin
          res_d   = '0;
          wr_d    = 1'b0;
          err_d   = 1'b1;
          state_d = RESP;
        end else if (mul_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_tick;
        if (!pcpi_valid) begin
          state_d = mul_rsp_valid ? HOLD : DRAIN;
        end else if (mul_rsp_valid) begin
          res_d   = rsp_sel;
          wr_d    = 1'b1;
          state_d = RESP;
        end else if (tmo) begin
          res_d   = '0;
          wr_d    = 1'b0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        res_d   = '0;
        wr_d    = 1'b0;
        state_d = HOLD;
      end
      HOLD: begin
        if (!pcpi_valid) state_d = IDLE;
      end
      DRAIN: begin
        if (mul_rsp_valid) state_d = HOLD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= MUL;
      res_q   <= '0;
      wr_q    <= 1'b0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      wr_q    <= wr_d;
      abort_q <= abort_d;
      err_q   <= err_d;
    end
  end

  assign pcpi_wait     = (state_q == ISSUE) || (state_q == WAIT);
  assign pcpi_ready    = (state_q == RESP);
  assign pcpi_wr       = (state_q == RESP) && wr_q;
  assign pcpi_rd       = (state_q == RESP) ? res_q : 32'd0;
  assign mul_req_valid = (state_q == ISSUE);
  assign mul_a         = a_q;
  assign mul_b         = b_q;
  assign err_timeout   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_pcpi_mul_shim.sv
// ---------------------------------------------------------------------------
// tb_pcpi_mul_shim: directed vectors with a response scoreboard.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pcpi_mul_shim;

  logic        clk;
  logic        resetn;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;
  logic        mul_req_valid;
  logic        mul_req_ready;
  logic [32:0] mul_a;
  logic [32:0] mul_b;
  logic        mul_rsp_valid;
  logic [63:0] mul_rsp_data;
  logic        err_timeout;

  int errors = 0;
  int checks = 0;
  logic [32:0] exp_q[$];
  int n_ready = 0;
  int n_req = 0;

  int   mlat;
  bit   mnever;
  bit   inject;
  int   cd;
  logic [63:0] prod_q;

  pcpi_mul_shim #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .pcpi_valid    (pcpi_valid),
    .pcpi_insn     (pcpi_insn),
    .pcpi_rs1      (pcpi_rs1),
    .pcpi_rs2      (pcpi_rs2),
    .pcpi_wr       (pcpi_wr),
    .pcpi_rd       (pcpi_rd),
    .pcpi_wait     (pcpi_wait),
    .pcpi_ready    (pcpi_ready),
    .mul_req_valid (mul_req_valid),
    .mul_req_ready (mul_req_ready),
    .mul_a         (mul_a),
    .mul_b         (mul_b),
    .mul_rsp_valid (mul_rsp_valid),
    .mul_rsp_data  (mul_rsp_data),
    .err_timeout   (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] prod_of(input logic [32:0] a, input logic [32:0] b);
    logic signed [65:0] sa, sb, p;
    sa = {{33{a[32]}}, a};
    sb = {{33{b[32]}}, b};
    p  = sa * sb;
    return p[63:0];
  endfunction

  function automatic logic [31:0] mk_insn(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  task automatic check(input string nm, input logic [65:0] act, input logic [65:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  // Behavioural multiplier: fixed latency after request accept, or silent.
  assign mul_rsp_valid = inject || (cd == 1) ||
                         (mlat == 0 && !mnever && mul_req_valid && mul_req_ready);
  assign mul_rsp_data  = (cd != 0) ? prod_q : prod_of(mul_a, mul_b);

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cd <= 0;
    end else if (mul_req_valid && mul_req_ready) begin
      n_req  <= n_req + 1;
      prod_q <= prod_of(mul_a, mul_b);
      cd     <= (mnever || mlat == 0) ? 0 : mlat;
    end else if (cd != 0) begin
      cd <= cd - 1;
    end
  end

  // Monitor: every completion pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (resetn && pcpi_ready) begin
      n_ready <= n_ready + 1;
      if (exp_q.size() == 0) begin
        check("unexpected_ready", {pcpi_wr, pcpi_rd}, 66'h3_DEAD_BEEF);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("rsp_wr", pcpi_wr, e[32]);
        check("rsp_rd", pcpi_rd, e[31:0]);
      end
    end
  end

  task automatic do_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input int lat, input logic exp_wr,
                       input logic [31:0] exp_rd, input logic [32:0] exp_a,
                       input logic [32:0] exp_b, input int exp_lat, input int hold_extra);
    int  n;
    bit  done;
    mlat       = lat;
    pcpi_insn  = mk_insn(7'b0000001, f3);
    pcpi_rs1   = a;
    pcpi_rs2   = b;
    exp_q.push_back({exp_wr, exp_rd});
    pcpi_valid = 1'b1;
    n    = 0;
    done = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      if (n == 1) begin
        check({nm, "_wait_rise"}, {pcpi_wait, mul_req_valid}, 2'b11);
        check({nm, "_mul_a"}, mul_a, exp_a);
        check({nm, "_mul_b"}, mul_b, exp_b);
      end
      if (pcpi_ready) done = 1;
      else n++;
    end
    if (!done) check({nm, "_ready_seen"}, 0, 1);
    else check({nm, "_latency"}, n, exp_lat);
    @(posedge clk);
    repeat (hold_extra) @(posedge clk);
    #1 pcpi_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic no_hit(input string nm, input logic [6:0] f7, input logic [2:0] f3);
    logic seen;
    seen       = 1'b0;
    pcpi_insn  = mk_insn(f7, f3);
    pcpi_rs1   = 32'd9;
    pcpi_rs2   = 32'd9;
    pcpi_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      seen = seen | pcpi_wait | pcpi_ready | pcpi_wr | mul_req_valid;
    end
    check(nm, seen, 1'b0);
    @(posedge clk);
    #1 pcpi_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r0, q0, n;
    resetn        = 1'b0;
    pcpi_valid    = 1'b0;
    pcpi_insn     = '0;
    pcpi_rs1      = '0;
    pcpi_rs2      = '0;
    mul_req_ready = 1'b1;
    mlat          = 0;
    mnever        = 0;
    inject        = 0;
    #3;
    check("reset_flags", {pcpi_wait, pcpi_ready, pcpi_wr, mul_req_valid, err_timeout}, 5'b0);
    check("reset_rd", pcpi_rd, 32'd0);
    check("reset_ab", {mul_a, mul_b}, 66'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);
    #1;

    do_op("mul",    3'b000, 32'hFFFFFFFD, 32'd7, 3, 1'b1, 32'hFFFFFFEB,
          33'h1FFFFFFFD, 33'h000000007, 5, 0);
    do_op("mulh",   3'b001, 32'hFFFFFFF6, 32'hFFFFFFFC, 2, 1'b1, 32'h00000000,
          33'h1FFFFFFF6, 33'h1FFFFFFFC, 4, 0);
    do_op("mulhsu", 3'b010, 32'hFFFFFFF6, 32'd4, 1, 1'b1, 32'hFFFFFFFF,
          33'h1FFFFFFF6, 33'h000000004, 3, 0);
    do_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 1'b1, 32'hFFFFFFFE,
          33'h0FFFFFFFF, 33'h0FFFFFFFF, 4, 0);

    no_hit("nonm_ignored", 7'b0000000, 3'b000);
    no_hit("div_ignored",  7'b0000001, 3'b100);

    r0 = n_ready;
    q0 = n_req;
    do_op("zerolat", 3'b011, 32'h80000000, 32'd4, 0, 1'b1, 32'h00000002,
          33'h080000000, 33'h000000004, 2, 3);
    check("zerolat_one_ready", n_ready - r0, 1);
    check("zerolat_one_req", n_req - q0, 1);

    // Abort: valid drops once the request is in WAIT; response lands in DRAIN.
    r0         = n_ready;
    mlat       = 3;
    pcpi_insn  = mk_insn(7'b0000001, 3'b000);
    pcpi_rs1   = 32'd11;
    pcpi_rs2   = 32'd13;
    pcpi_valid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 pcpi_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_ready", n_ready - r0, 0);
    check("abort_idle", {pcpi_wait, mul_req_valid}, 2'b00);
    do_op("after_abort", 3'b000, 32'd5, 32'd6, 1, 1'b1, 32'd30,
          33'h000000005, 33'h000000006, 3, 0);

    mnever = 1;
    do_op("timeout", 3'b000, 32'd5, 32'd6, 2, 1'b0, 32'd0,
          33'h000000005, 33'h000000006, 9, 0);
    check("timeout_err_set", err_timeout, 1'b1);
    r0     = n_ready;
    inject = 1;
    @(posedge clk);
    #1 inject = 0;
    repeat (3) @(posedge clk);
    #1;
    check("late_rsp_ignored", {n_ready - r0, pcpi_wait}, 33'd0);
    check("timeout_err_sticky", err_timeout, 1'b1);

    pcpi_insn  = mk_insn(7'b0000001, 3'b001);
    pcpi_valid = 1'b1;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      if (pcpi_wait && !mul_req_valid) break;
      n++;
    end
    check("reached_wait", n < 10, 1'b1);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_flags", {pcpi_wait, pcpi_ready, pcpi_wr, mul_req_valid, err_timeout}, 5'b0);
    check("async_rst_data", {pcpi_rd, mul_a[31:0]}, 64'd0);
    pcpi_valid = 1'b0;
    mnever     = 0;
    @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);
    #1;
    do_op("after_reset", 3'b000, 32'h7FFFFFFF, 32'd2, 2, 1'b1, 32'hFFFFFFFE,
          33'h07FFFFFFF, 33'h000000002, 4, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/pcpi_mul_shim.md
Name: pcpi_mul_shim

Overview:
- Front-end stage between the core's PCPI bus and a standalone 33x33 signed multiplier core.
- Decodes RV32M MUL/MULH/MULHSU/MULHU and sign/zero-extends operands to 33 bits.
- Issues the product request over a valid/ready channel and selects the low or high result half for `pcpi_rd`.
- Owns the PCPI handshake: `pcpi_wait`, the `pcpi_ready` pulse, abort and watchdog timeout.

Parameters:
- TIMEOUT_CYCLES, 64: cycles from request issue to response before forced completion; 0 disables the watchdog.
- CNT_W, 7: width of the watchdog counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- pcpi_valid  in  1  core request; held high until `pcpi_ready` is seen.
- pcpi_insn  in  32  instruction word.
- pcpi_rs1  in  32  operand 1.
- pcpi_rs2  in  32  operand 2.
- pcpi_wr  out  1  result is valid for writeback (qualified by `pcpi_ready`).
- pcpi_rd  out  32  result.
- pcpi_wait  out  1  instruction claimed, result pending.
- pcpi_ready  out  1  single-cycle completion pulse.
- mul_req_valid  out  1  request to the multiplier.
- mul_req_ready  in  1  multiplier accepts the request.
- mul_a  out  33  extended operand A.
- mul_b  out  33  extended operand B.
- mul_rsp_valid  in  1  product valid, one-cycle pulse.
- mul_rsp_data  in  64  low 64 bits of the signed 66-bit product.
- err_timeout  out  1  sticky; set when the watchdog fires, cleared only by reset.

Behaviour:
- Decode hit: `insn[6:0]`=0110011, `insn[31:25]`=0000001 and `insn[14]`=0. `op`=`insn[13:12]`.
- Non-hits are ignored: `pcpi_wait`, `pcpi_ready` and `pcpi_wr` stay 0.
- Operand extension:
  - `mul_a` = {rs1[31], rs1} for ops 00/01/10; {0, rs1} for op 11.
  - `mul_b` = {rs2[31], rs2} for ops 00/01; {0, rs2} for ops 10/11.
- Result select: op 00 gives `rsp[31:0]`; all other ops give `rsp[63:32]`.
- Operands and op are latched on accept; later changes to `pcpi_rs*`/`pcpi_insn` have no effect.
- Reset (async, any state): state=IDLE, counter=0. All outputs are 0, including `err_timeout`, `mul_a`, `mul_b` and `pcpi_rd`.
- The multiplier shares `resetn`, so no in-flight response survives reset.
- FSM:
  - IDLE: on `pcpi_valid`&hit, latch operands and go to ISSUE.
  - ISSUE: `mul_req_valid`=1, `pcpi_wait`=1, counter counts.
    - On `mul_req_ready`, go to WAIT.
    - If `mul_rsp_valid` arrives in the same cycle as `mul_req_ready` (zero-latency multiplier), capture the result and go directly to RESP.
  - WAIT: `pcpi_wait`=1. On `mul_rsp_valid`, capture the selected half into the result register and go to RESP.
  - RESP (exactly 1 cycle): `pcpi_ready`=1, `pcpi_wr`=1, `pcpi_rd`=result, `pcpi_wait`=0. Then go to HOLD.
  - HOLD: all PCPI outputs 0. Stay until `pcpi_valid`=0, then go to IDLE. This blocks re-accepting the same instruction while the core is still dropping valid.
  - DRAIN: entered on abort. `pcpi_wait`=0; wait for `mul_rsp_valid`, discard it, then go to HOLD.
- Abort:
  - `pcpi_valid` falls in WAIT: go to DRAIN.
  - `pcpi_valid` falls in ISSUE: keep `mul_req_valid` until accepted (no valid retraction), then go to DRAIN.
- Timeout (TIMEOUT_CYCLES>0): when the counter reaches TIMEOUT_CYCLES in ISSUE or WAIT:
  - `err_timeout` is set and the state goes to RESP with `pcpi_wr`=0 and `pcpi_rd`=0.
  - A late `mul_rsp_valid` is ignored in every state other than ISSUE and WAIT.
- Latency: `pcpi_wait` rises 1 cycle after valid&hit. With multiplier latency L (`mul_req_ready` immediate), `pcpi_ready` appears L+2 cycles after accept.
- `pcpi_rd` holds its value only during RESP and is 0 otherwise.

Decomposition:
- Shared package `pcpi_pkg`:
  - Constants OPC_OP=7'b0110011 and F7_MULDIV=7'b0000001.
  - Enum `mul_op_t` {MUL, MULH, MULHSU, MULHU}.
  - State enum {IDLE, ISSUE, WAIT, RESP, HOLD, DRAIN}.
- One sub-module is natural: `pcpi_mul_decode`, combinational. It takes `insn` and the operands and produces `hit`, `op`, `mul_a` and `mul_b`.

Test Plan:
- MUL rs1=-3 (0xFFFFFFFD), rs2=7, 3-cycle multiplier -> `mul_a`=0x1FFFFFFFD, `mul_b`=0x000000007; `pcpi_ready`+`pcpi_wr` pulse with `pcpi_rd`=0xFFFFFFEB, 5 cycles after accept.
- MULH -10×-4, MULHSU -10×4, MULHU 0xFFFFFFFF×0xFFFFFFFF -> `pcpi_rd` = 0x00000000, 0xFFFFFFFF, 0xFFFFFFFE; MULHSU `mul_b`=0x000000004.
- Non-M insn (funct7=0000000), or DIV (funct3=100) with valid held 20 cycles -> `pcpi_wait`, `pcpi_ready` and `mul_req_valid` stay 0.
- Zero-latency multiplier (`rsp_valid` same cycle as `req_ready`); valid held 3 cycles after ready -> exactly one `pcpi_ready` pulse, no second request.
- Drop `pcpi_valid` in WAIT, response arrives 2 cycles later -> no `pcpi_ready`; next MUL 5×6 returns 30.
- TIMEOUT_CYCLES=8, multiplier never responds -> `pcpi_ready`=1 with `pcpi_wr`=0 at counter 8, `err_timeout`=1 and stays 1; a late `rsp_valid` is ignored. Async reset mid-WAIT clears all outputs immediately.
